game_timer: RTL and testbench

GAME_TIMER -- requirements
Module: game_timer

---
 rtl/game_timer.sv | 146 ++++++++++++++
 tb/tb_game_timer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_timer.sv
// Countdown game timer: loads a per-mode second count, ticks it down once per
// TICKS_PER_SEC enabled cycles and pulses Timeout on expiry. GAME_TIMER_BCD_EN adds BCD digit outputs.
module game_timer #(
  parameter int unsigned TICKS_PER_SEC = 50000000,
  parameter int unsigned MODE0_SEC     = 60,
  parameter int unsigned MODE1_SEC     = 45,
  parameter int unsigned MODE2_SEC     = 30,
  parameter int unsigned MODE3_SEC     = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ReconfigTimer,
  input  logic       enable,
  input  logic [1:0] mode,
  output logic       Timeout,
  output logic [6:0] SecLeft,
`ifdef GAME_TIMER_BCD_EN
  output logic [3:0] SecTens,
  output logic [3:0] SecOnes,
`endif
  output logic       Expired
);

  localparam int unsigned PW = $clog2(TICKS_PER_SEC);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOADED  = 2'd1,
    S_EXPIRED = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [6:0]      sec_q, sec_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            timeout_q, timeout_d;
  // Set by a zero-second load so Timeout fires one cycle after the load edge.
  logic            zero_pend_q, zero_pend_d;

  function automatic logic [6:0] load_sec(input logic [1:0] m);
    case (m)
      2'd0:    return 7'(MODE0_SEC);
      2'd1:    return 7'(MODE1_SEC);
      2'd2:    return 7'(MODE2_SEC);
      default: return 7'(MODE3_SEC);
    endcase
  endfunction

`ifdef GAME_TIMER_BCD_EN
  logic [3:0] tens_q, tens_d, ones_q, ones_d;

  function automatic logic [7:0] load_bcd(input logic [1:0] m);
    case (m)
      2'd0:    return {4'(MODE0_SEC / 10), 4'(MODE0_SEC % 10)};
      2'd1:    return {4'(MODE1_SEC / 10), 4'(MODE1_SEC % 10)};
      2'd2:    return {4'(MODE2_SEC / 10), 4'(MODE2_SEC % 10)};
      default: return {4'(MODE3_SEC / 10), 4'(MODE3_SEC % 10)};
    endcase
  endfunction
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    sec_d       = sec_q;
    presc_d     = presc_q;
    timeout_d   = 1'b0;
    zero_pend_d = 1'b0;
`ifdef GAME_TIMER_BCD_EN
    tens_d      = tens_q;
    ones_d      = ones_q;
`endif
    if (ReconfigTimer) begin
      // A load wins over any wrap on the same edge, so no Timeout is raised here.
      sec_d       = load_sec(mode);
      presc_d     = '0;
      zero_pend_d = (load_sec(mode) == 7'd0);
      state_d     = (load_sec(mode) == 7'd0) ? S_EXPIRED : S_LOADED;
`ifdef GAME_TIMER_BCD_EN
      {tens_d, ones_d} = load_bcd(mode);
`endif
    end else begin
      case (state_q)
        S_LOADED: begin
          if (enable) begin
            if (presc_q == PW'(TICKS_PER_SEC - 1)) begin
              presc_d = '0;
              sec_d   = sec_q - 7'd1;
`ifdef GAME_TIMER_BCD_EN
              if (ones_q == 4'd0) begin
                ones_d = 4'd9;
                tens_d = tens_q - 4'd1;
              end else begin
                ones_d = ones_q - 4'd1;
              end
`endif
              if (sec_q == 7'd1) begin
                state_d   = S_EXPIRED;
                timeout_d = 1'b1;
              end
            end else begin
              presc_d = presc_q + PW'(1);
            end
          end
        end
        S_EXPIRED: timeout_d = zero_pend_q;
        default:   ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sec_q       <= '0;
      presc_q     <= '0;
      timeout_q   <= 1'b0;
      zero_pend_q <= 1'b0;
`ifdef GAME_TIMER_BCD_EN
      tens_q      <= '0;
      ones_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sec_q       <= sec_d;
      presc_q     <= presc_d;
      timeout_q   <= timeout_d;
      zero_pend_q <= zero_pend_d;
`ifdef GAME_TIMER_BCD_EN
      tens_q      <= tens_d;
      ones_q      <= ones_d;
`endif
    end
  end

  assign Timeout = timeout_q;
  assign SecLeft = sec_q;
  assign Expired = (state_q == S_EXPIRED);
`ifdef GAME_TIMER_BCD_EN
  assign SecTens = tens_q;
  assign SecOnes = ones_q;
`endif

endmodule

// File: tb/tb_game_timer.sv
// Self-checking bench for game_timer: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against an elapsed-cycle model.
module tb_game_timer;

  localparam int T  = 4;
  localparam int M0 = 11;
  localparam int M1 = 3;
  localparam int M2 = 30;
  localparam int M3 = 0;

  logic       clk = 1'b0;
  logic       rst, ReconfigTimer, enable;
  logic [1:0] mode;
  logic       Timeout, Expired;
  logic [6:0] SecLeft;
`ifdef GAME_TIMER_BCD_EN
  logic [3:0] SecTens, SecOnes;
`endif

  game_timer #(
    .TICKS_PER_SEC(T), .MODE0_SEC(M0), .MODE1_SEC(M1), .MODE2_SEC(M2), .MODE3_SEC(M3)
  ) dut (
    .clk(clk), .rst(rst), .ReconfigTimer(ReconfigTimer), .enable(enable), .mode(mode),
    .Timeout(Timeout), .SecLeft(SecLeft),
`ifdef GAME_TIMER_BCD_EN
    .SecTens(SecTens), .SecOnes(SecOnes),
`endif
    .Expired(Expired)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: remaining seconds = load - (enabled cycles since load) / T.
  typedef enum int {M_IDLE, M_RUN, M_DONE} mstate_e;
  mstate_e m_state = M_IDLE;
  int      m_load  = 0;
  int      m_ecnt  = 0;
  bit      m_to    = 1'b0;
  bit      m_pend  = 1'b0;

  function automatic int mode_secs(input logic [1:0] m);
    case (m)
      2'd0:    return M0;
      2'd1:    return M1;
      2'd2:    return M2;
      default: return M3;
    endcase
  endfunction

  function automatic int m_sec();
    return (m_state == M_RUN) ? m_load - m_ecnt / T : 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_state = M_IDLE; m_to = 1'b0; m_pend = 1'b0; m_ecnt = 0;
    end else if (ReconfigTimer) begin
      m_load = mode_secs(mode);
      m_ecnt = 0;
      m_to   = 1'b0;
      m_pend = (m_load == 0);
      m_state = (m_load == 0) ? M_DONE : M_RUN;
    end else begin
      m_to = 1'b0;
      if (m_state == M_RUN && enable) begin
        m_ecnt++;
        if (m_ecnt == m_load * T) begin
          m_state = M_DONE;
          m_to    = 1'b1;
        end
      end else if (m_state == M_DONE && m_pend) begin
        m_to   = 1'b1;
        m_pend = 1'b0;
      end
    end
  end

  bit chk_en  = 1'b0;
  bit prev_to = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("sec_left", 32'(SecLeft), 32'(m_sec()));
      check("timeout",  32'(Timeout), 32'(m_to));
      check("expired",  32'(Expired), 32'(m_state == M_DONE));
      check("timeout_single", 32'(prev_to & Timeout), 32'd0);
`ifdef GAME_TIMER_BCD_EN
      check("sec_tens", 32'(SecTens), 32'(m_sec() / 10));
      check("sec_ones", 32'(SecOnes), 32'(m_sec() % 10));
`endif
      prev_to = Timeout;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [1:0] m);
    ReconfigTimer = 1'b1; mode = m;
    tick();
    ReconfigTimer = 1'b0;
  endtask

  int hold;

  initial begin
    rst = 1'b1; ReconfigTimer = 1'b1; enable = 1'b1; mode = 2'd1;
    tick(2);
    rst = 1'b0; ReconfigTimer = 1'b0;
    check("rst_sec", 32'(SecLeft), 32'd0);
    check("rst_to",  32'(Timeout), 32'd0);
    check("rst_exp", 32'(Expired), 32'd0);
    chk_en = 1'b1;

    // Plain countdown from 3 seconds.
    enable = 1'b1;
    load(2'd1);
    check("load3_sec", 32'(SecLeft), 32'd3);
    tick(4);  check("dec_2", 32'(SecLeft), 32'd2);
    tick(4);  check("dec_1", 32'(SecLeft), 32'd1);
    tick(3);  check("pre_exp_to", 32'(Timeout), 32'd0);
    tick();   check("exp_sec", 32'(SecLeft), 32'd0);
              check("exp_to", 32'(Timeout), 32'd1);
              check("exp_lvl", 32'(Expired), 32'd1);
    tick();   check("exp_to_clr", 32'(Timeout), 32'd0);
              check("exp_hold", 32'(Expired), 32'd1);

    // Pause of 5 cycles after 2 enabled cycles delays expiry by 5.
    load(2'd1);
    tick(2);
    enable = 1'b0; tick(5);
    check("pause_hold", 32'(SecLeft), 32'd3);
    enable = 1'b1; tick(9);
    check("pause_sec1", 32'(SecLeft), 32'd1);
    check("pause_to0", 32'(Timeout), 32'd0);
    tick();
    check("pause_exp_to", 32'(Timeout), 32'd1);

    // Reload on the 1->0 wrap edge wins.
    load(2'd1);
    tick(11);
    ReconfigTimer = 1'b1; mode = 2'd1;
    tick();
    ReconfigTimer = 1'b0;
    check("collide_sec", 32'(SecLeft), 32'd3);
    check("collide_to",  32'(Timeout), 32'd0);
    check("collide_exp", 32'(Expired), 32'd0);
    tick();
    check("collide_to2", 32'(Timeout), 32'd0);

    // Zero-second load with enable low.
    enable = 1'b0;
    load(2'd3);
    check("zero_exp", 32'(Expired), 32'd1);
    check("zero_to0", 32'(Timeout), 32'd0);
    tick();
    check("zero_to1", 32'(Timeout), 32'd1);
    check("zero_sec", 32'(SecLeft), 32'd0);
    tick();
    check("zero_to_clr", 32'(Timeout), 32'd0);

    // Reset mid-count discards the countdown.
    enable = 1'b1;
    load(2'd2);
    tick(6);
    rst = 1'b1; ReconfigTimer = 1'b1;
    tick();
    rst = 1'b0; ReconfigTimer = 1'b0;
    check("midrst_sec", 32'(SecLeft), 32'd0);
    check("midrst_exp", 32'(Expired), 32'd0);
    tick(3);
    check("midrst_to", 32'(Timeout), 32'd0);

`ifdef GAME_TIMER_BCD_EN
    load(2'd0);
    check("bcd_11", {24'd0, SecTens, SecOnes}, 32'h11);
    tick(4);
    check("bcd_10", {24'd0, SecTens, SecOnes}, 32'h10);
    tick(4);
    check("bcd_09", {24'd0, SecTens, SecOnes}, 32'h09);
`endif

    // Randomized traffic; the per-cycle compare process does the checking.
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (hold > 0) begin
        hold--;
        ReconfigTimer = 1'b1;
      end else if ($urandom_range(0, 59) == 0) begin
        ReconfigTimer = 1'b1;
        hold = $urandom_range(0, 2);
      end else begin
        ReconfigTimer = 1'b0;
      end
      enable = ($urandom_range(0, 3) != 0);
      mode   = 2'($urandom_range(0, 3));
      tick();
    end

    rst = 1'b0; ReconfigTimer = 1'b0;
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
